// File: rtl/fifo_prefetch_stream_if.sv
// Upstream FIFO read port and downstream valid/ready stream
// bundled for fifo_prefetch_stream.
interface fifo_prefetch_stream_if #(
  parameter int WIDTH = 32
);
  logic             fifoEmpty;
  logic             readFromFIFO;
  logic [WIDTH-1:0] dataFromFIFO;
  logic             dataFromFIFOValid;
  logic             outReady;
  logic             outValid;
  logic [WIDTH-1:0] outData;
  logic             overflowError;

  modport master (
    input  fifoEmpty,
    input  dataFromFIFO,
    input  dataFromFIFOValid,
    input  outReady,
    output readFromFIFO,
    output outValid,
    output outData,
    output overflowError
  );

  modport slave (
    output fifoEmpty,
    output dataFromFIFO,
    output dataFromFIFOValid,
    output outReady,
    input  readFromFIFO,
    input  outValid,
    input  outData,
    input  overflowError
  );
endinterface

// File: rtl/fifo_prefetch_stream.sv
// Turns a fixed-latency FIFO read port into a first-word-fall-through
// valid/ready stream using credit-tracked speculative reads.
module fifo_prefetch_stream #(
  parameter int WIDTH          = 32,
  parameter int READ_LATENCY   = 4,
  parameter int BUF_DEPTH_LOG2 = 3
) (
  input logic clk,
  input logic rst,
  fifo_prefetch_stream_if.master bus
);
  localparam int BUF_DEPTH = 1 << BUF_DEPTH_LOG2;
  localparam int CW = BUF_DEPTH_LOG2 + 1;
  localparam int PW = BUF_DEPTH_LOG2;
  localparam int DW =
    (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [DW-1:0] DRAIN_C = DW'(READ_LATENCY);

  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    in_flight;
  logic [CW-1:0]    stored;
  logic [CW-1:0]    credits;
  logic [CW-1:0]    in_flight_nxt;
  logic [CW-1:0]    stored_nxt;
  logic [DW-1:0]    drain_cnt;
  logic             out_valid;
  logic             overflow;
  logic             draining;
  logic             rd_req;
  logic             vld_in;
  logic             bad;
  logic             wr;
  logic             pop;

  // Request/accept decisions, all from registers plus live inputs.
  always_comb begin
    draining = (drain_cnt != '0);
    credits  = DEPTH_C - stored - in_flight;
    rd_req   = !bus.fifoEmpty && (credits != '0) && !draining;
    vld_in   = bus.dataFromFIFOValid && !draining;
    bad      = vld_in &&
               ((in_flight == '0) || (stored == DEPTH_C));
    wr       = vld_in && !bad;
    pop      = out_valid && bus.outReady;
  end

  // Next values of the in-flight and stored counters.
  always_comb begin
    in_flight_nxt = in_flight;
    stored_nxt    = stored;
    if (rd_req && !wr)
      in_flight_nxt = in_flight + CW'(1);
    else if (!rd_req && wr)
      in_flight_nxt = in_flight - CW'(1);
    if (wr && !pop)
      stored_nxt = stored + CW'(1);
    else if (!wr && pop)
      stored_nxt = stored - CW'(1);
  end

  // Control state: drain window, counters, pointers, error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt <= DRAIN_C;
      in_flight <= '0;
      stored    <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (draining)
        drain_cnt <= drain_cnt - DW'(1);
      in_flight <= in_flight_nxt;
      stored    <= stored_nxt;
      out_valid <= (stored_nxt != '0);
      if (wr)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (bad)
        overflow <= 1'b1;
    end
  end

  // Skid buffer storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr && !rst)
      mem[wr_ptr] <= bus.dataFromFIFO;
  end

  assign bus.readFromFIFO  = rd_req;
  assign bus.outValid      = out_valid;
  assign bus.outData       = mem[rd_ptr];
  assign bus.overflowError = overflow;
endmodule

// File: tb/tb_fifo_prefetch_stream.sv
// Bench for fifo_prefetch_stream: upstream FIFO model with fixed
// read latency, directed scenarios, scoreboard-driven output monitor.
module tb_fifo_prefetch_stream;
  localparam int W   = 32;
  localparam int RL  = 4;
  localparam int DL2 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_prefetch_stream_if #(.WIDTH(W)) bus ();

  fifo_prefetch_stream #(
    .WIDTH(W),
    .READ_LATENCY(RL),
    .BUF_DEPTH_LOG2(DL2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [W-1:0]  fmem [0:255];
  int            fwr = 0;
  int            frd = 0;
  logic [RL-1:0] pv = '0;
  logic [W-1:0]  pd [0:RL-1];
  logic          hold_empty = 1'b1;
  logic          tog_empty = 1'b0;
  logic          ready = 1'b0;
  logic          force_v = 1'b0;
  logic [W-1:0]  force_d = '0;
  int            cyc = 0;
  int            reads = 0;
  int            vlds = 0;
  int            checks = 0;
  int            passes = 0;
  logic [W-1:0]  sb [$];

  // Upstream FIFO: pops on request, returns data RL cycles later.
  always @(posedge clk) begin
    cyc <= rst ? 0 : cyc + 1;
    pv <= {pv[RL-2:0], bus.readFromFIFO};
    pd[0] <= fmem[frd[7:0]];
    for (int i = 1; i < RL; i++) pd[i] <= pd[i-1];
    if (bus.readFromFIFO) begin
      frd <= frd + 1;
      reads <= reads + 1;
    end
    if (pv[RL-1]) vlds <= vlds + 1;
  end

  // Drive DUT inputs from the model and stimulus knobs.
  always_comb begin
    bus.fifoEmpty = hold_empty || (frd == fwr) ||
                    (tog_empty && cyc[0]);
    bus.dataFromFIFOValid = pv[RL-1] || force_v;
    bus.dataFromFIFO = force_v ? force_d : pd[RL-1];
    bus.outReady = ready;
  end

  task automatic check(string name,
                       logic [W-1:0] act,
                       logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic preload(int n, int base);
    for (int i = 0; i < n; i++) begin
      fmem[fwr[7:0]] = W'(base + i);
      fwr++;
      sb.push_back(W'(base + i));
    end
  endtask

  task automatic wait_drain(string name, int lim);
    int k;
    k = 0;
    while (sb.size() != 0 && k < lim) begin
      tick();
      k++;
    end
    check(name, W'(sb.size()), W'(0));
  endtask

  // Monitor: pops expected words on every handshake, checks holds.
  initial begin
    logic         ph;
    logic [W-1:0] pdat;
    ph = 1'b0;
    pdat = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ph = 1'b0;
      end else begin
        if (ph) begin
          check("hold_valid", W'(bus.outValid), W'(1));
          check("hold_data", bus.outData, pdat);
        end
        if (bus.outValid && bus.outReady) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL extra_word: got %0h expected none",
                     bus.outData);
          end else begin
            check("out_word", bus.outData, sb.pop_front());
          end
        end
        ph = bus.outValid && !bus.outReady;
        pdat = bus.outData;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int r0;
    int v0;
    repeat (2) tick();

    // Drain window with an empty FIFO.
    hold_empty = 1'b0;
    do_reset();
    check("rst_valid", W'(bus.outValid), W'(0));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t1_read", W'(bus.readFromFIFO), W'(0));
      check("t1_valid", W'(bus.outValid), W'(0));
      check("t1_ovf", W'(bus.overflowError), W'(0));
    end

    // Full throughput stream of 1..20.
    tick();
    hold_empty = 1'b1;
    preload(20, 1);
    ready = 1'b1;
    do_reset();
    hold_empty = 1'b0;
    r0 = reads;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check("t2_read", W'(bus.readFromFIFO),
            W'(k >= 4 && k < 24));
      check("t2_valid", W'(bus.outValid),
            W'(k >= 9 && k < 29));
    end
    wait_drain("t2_drain", 100);
    check("t2_reads", W'(reads - r0), W'(20));

    // Consumer stalled: credits cap reads at buffer depth.
    tick();
    hold_empty = 1'b1;
    preload(20, 1);
    ready = 1'b0;
    do_reset();
    hold_empty = 1'b0;
    r0 = reads;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k >= 12)
        check("t3_read", W'(bus.readFromFIFO), W'(0));
      if (k >= 9) begin
        check("t3_valid", W'(bus.outValid), W'(1));
        check("t3_head", bus.outData, W'(1));
      end
    end
    check("t3_reads", W'(reads - r0), W'(8));
    check("t3_stored", W'(dut.stored), W'(8));
    tick();
    ready = 1'b1;
    wait_drain("t3_drain", 200);
    check("t3_total", W'(reads - r0), W'(20));

    // Toggling ready and empty: order, holds, no extra reads.
    tick();
    hold_empty = 1'b1;
    preload(16, 1);
    ready = 1'b1;
    tog_empty = 1'b1;
    do_reset();
    hold_empty = 1'b0;
    r0 = reads;
    for (int k = 0; k < 300 && sb.size() != 0; k++) begin
      tick();
      ready = ~ready;
    end
    check("t4_drain", W'(sb.size()), W'(0));
    check("t4_reads", W'(reads - r0), W'(16));
    tog_empty = 1'b0;
    ready = 1'b0;

    // Reset with 3 in flight and 5 stored.
    tick();
    hold_empty = 1'b1;
    preload(20, 1);
    do_reset();
    hold_empty = 1'b0;
    r0 = reads;
    v0 = vlds;
    repeat (13) tick();
    check("t5_reads", W'(reads - r0), W'(8));
    check("t5_stored", W'(dut.stored), W'(5));
    check("t5_inflight", W'(dut.in_flight), W'(3));
    hold_empty = 1'b1;
    fwr = frd;
    sb.delete();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t5_valid", W'(bus.outValid), W'(0));
      check("t5_ovf", W'(bus.overflowError), W'(0));
    end
    check("t5_late", W'(vlds - v0), W'(8));
    tick();
    fmem[fwr[7:0]] = W'(32'hAB);
    fwr++;
    sb.push_back(W'(32'hAB));
    ready = 1'b1;
    hold_empty = 1'b0;
    wait_drain("t5_drain", 50);
    check("t5_ovf_end", W'(bus.overflowError), W'(0));

    // Spurious valid with nothing in flight.
    repeat (3) tick();
    force_d = W'(32'hDEADBEEF);
    force_v = 1'b1;
    tick();
    force_v = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t6_ovf", W'(bus.overflowError), W'(1));
      check("t6_valid", W'(bus.outValid), W'(0));
    end
    check("t6_stored", W'(dut.stored), W'(0));
    tick();
    do_reset();
    @(negedge clk);
    check("t6_ovf_rst", W'(bus.overflowError), W'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
